mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result-half width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, with synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to begin an operation.
REQ-005 The block SHALL have port op, input, 1: 0 = multiply, 1 = divide.
REQ-006 The block SHALL have port opA, input, WIDTH, the multiplicand or dividend, driven from register-file ReadData1.
REQ-007 The block SHALL have port opB, input, WIDTH, the multiplier or divisor, driven from register-file ReadData2.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port hi, output, WIDTH: the product upper half, or the remainder.
REQ-011 The block SHALL have port lo, output, WIDTH: the product lower half, or the quotient.
REQ-012 The block SHALL have port divByZero, output, 1, high when the last completed divide had opB = 0.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; with MDU_SIGNED_EN it SHALL also have state FIX.
REQ-014 start SHALL be accepted only at a rising edge in IDLE or DONE; opA, opB and op SHALL be latched at that edge, and later input changes SHALL be ignored.
REQ-015 start SHALL be ignored while busy = 1, with no effect on state, operands or outputs.
REQ-016 From IDLE or DONE, an accepted start SHALL move the FSM to RUN, clear the iteration counter, and set busy = 1 from the next cycle.
REQ-017 Multiply SHALL use shift-add, one partial-product bit per cycle, producing a 2*WIDTH-bit unsigned product.
REQ-018 Divide SHALL use restoring division, one quotient bit per cycle, producing unsigned quotient and remainder.
REQ-019 RUN SHALL last exactly WIDTH cycles; on the WIDTH-th iteration edge the FSM SHALL enter DONE and load hi and lo.
REQ-020 done SHALL be high for exactly the one cycle spent in DONE, and busy SHALL be 0 in that cycle.
REQ-021 The latency from the start-accept edge to done high SHALL be WIDTH cycles.
REQ-022 DONE SHALL return to IDLE after one cycle, unless start is accepted in DONE, in which case it SHALL go to RUN.
REQ-023 A divide with latched opB = 0 SHALL skip RUN and enter DONE on the next edge, giving done 1 cycle after start, lo = all ones, hi = opA and divByZero = 1.
REQ-024 divByZero SHALL update only on completion: 1 for a zero-divisor divide, 0 for every other operation.
REQ-025 hi and lo SHALL hold their last completed results until the next completion, and SHALL not change at start or during RUN.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 With reset = 1 at a rising edge, the FSM SHALL go to IDLE, and busy, done, divByZero, hi, lo and the counter SHALL all become 0.
REQ-028 Reset SHALL take priority over start.
REQ-029 Reset during RUN SHALL abort the operation with no done pulse, and hi and lo SHALL read 0.

Configuration
REQ-030 With macro MDU_SIGNED_EN defined, the block SHALL add input port signedOp, 1 bit, latched at start.
REQ-031 When signedOp = 1, operands SHALL be converted to magnitudes before RUN, and FIX SHALL apply the sign corrections for one cycle after RUN, giving latency WIDTH+1.
REQ-032 Signed divide SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-033 When signedOp = 0, or when MDU_SIGNED_EN is undefined, the block SHALL behave as unsigned-only with latency WIDTH.
REQ-034 When MDU_SIGNED_EN is undefined, the signedOp port and the FIX state SHALL be absent.

Verification
REQ-035 Multiply 13×11: with WIDTH = 8, op = 0, opA = 13, opB = 11 and start for 1 cycle, the bench SHALL see busy for 8 cycles, then done with hi = 0x00 and lo = 0x8F.
REQ-036 Multiply 200×200: with op = 0, opA = 200 and opB = 200, the bench SHALL see hi = 0x9C and lo = 0x40.
REQ-037 Divide 100/7: with op = 1, opA = 100 and opB = 7, the bench SHALL see lo = 0x0E, hi = 0x02 and divByZero = 0, plus a second start issued mid-RUN being ignored.
REQ-038 Divide by zero: with op = 1, opA = 0x55 and opB = 0, the bench SHALL see done 1 cycle after start, with lo = 0xFF, hi = 0x55 and divByZero = 1.
REQ-039 Reset mid-run: with reset asserted 4 cycles into a multiply, the bench SHALL see busy = 0 on the next cycle, no done pulse, and hi = lo = 0x00; back-to-back start in the DONE cycle SHALL be accepted.
REQ-040 Signed cases under MDU_SIGNED_EN with signedOp = 1: -7×3 SHALL give hi = 0xFF and lo = 0xEB after 9 cycles; -7/2 SHALL give lo = 0xFD and hi = 0xFF.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential multiply/divide unit.
// Multiply is shift-add and divide is restoring division; both produce one bit per cycle.
// Optional signed support is compiled in when the macro MDU_SIGNED_EN is defined.
// That build adds the signedOp port and the FIX state.
module mult_div_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MDU_SIGNED_EN
  input  logic             signedOp,
`endif
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

`ifdef MDU_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t state, state_next;

  // Operation context captured at the accept edge
  logic             op_q;
  logic             zero_div_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] b_q;

  // Working registers: {product hi, multiplier} or {partial remainder, quotient}
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

`ifdef MDU_SIGNED_EN
  logic               sign_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
`endif

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == LAST_ITER);

  // Operand magnitudes; the signed build strips signs so the core stays unsigned
  always_comb begin
    mag_a = opA;
    mag_b = opB;
`ifdef MDU_SIGNED_EN
    if (signedOp && opA[WIDTH-1]) mag_a = -opA;
    if (signedOp && opB[WIDTH-1]) mag_b = -opB;
`endif
  end

  // One iteration of either shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_q} : '0);
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!op_q) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end else if (div_diff[WIDTH]) begin
      step_hi = div_shift[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], 1'b0};
    end else begin
      step_hi = div_diff[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], 1'b1};
    end
  end

`ifdef MDU_SIGNED_EN
  // Sign correction applied in FIX: remainder follows the dividend, quotient truncates to zero
  always_comb begin
    fix_prod = {work_hi, work_lo};
    fix_hi   = work_hi;
    fix_lo   = work_lo;
    if (!op_q) begin
      if (neg_res_q) fix_prod = -{work_hi, work_lo};
      fix_hi = fix_prod[2*WIDTH-1:WIDTH];
      fix_lo = fix_prod[WIDTH-1:0];
    end else begin
      if (neg_res_q) fix_lo = -work_lo;
      if (neg_rem_q) fix_hi = -work_hi;
    end
  end
`endif

  // Next-state logic; a zero divisor short-circuits straight from RUN to DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (zero_div_q) begin
          state_next = DONE;
        end else if (last_iter) begin
`ifdef MDU_SIGNED_EN
          state_next = sign_q ? FIX : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef MDU_SIGNED_EN
      FIX:  state_next = DONE;
`endif
      DONE: state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset wins over any pending start
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath and registered outputs; hi/lo only change on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      divByZero  <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      cnt        <= '0;
      op_q       <= 1'b0;
      zero_div_q <= 1'b0;
      dividend_q <= '0;
      b_q        <= '0;
      work_hi    <= '0;
      work_lo    <= '0;
`ifdef MDU_SIGNED_EN
      sign_q     <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      busy <= (state_next != IDLE) && (state_next != DONE);
      done <= (state_next == DONE);
      if (accept) begin
        op_q       <= op;
        zero_div_q <= op && (opB == '0);
        dividend_q <= opA;
        cnt        <= '0;
        work_hi    <= '0;
        work_lo    <= op ? mag_a : mag_b;
        b_q        <= op ? mag_b : mag_a;
`ifdef MDU_SIGNED_EN
        sign_q     <= signedOp;
        neg_res_q  <= signedOp && (opA[WIDTH-1] ^ opB[WIDTH-1]);
        neg_rem_q  <= signedOp && opA[WIDTH-1];
`endif
      end else if (state == RUN) begin
        if (zero_div_q) begin
          hi        <= dividend_q;
          lo        <= '1;
          divByZero <= 1'b1;
        end else begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          cnt     <= cnt + 1'b1;
          if (last_iter && (state_next == DONE)) begin
            hi        <= step_hi;
            lo        <= step_lo;
            divByZero <= 1'b0;
          end
        end
      end
`ifdef MDU_SIGNED_EN
      else if (state == FIX) begin
        hi        <= fix_hi;
        lo        <= fix_lo;
        divByZero <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven checks of mult_div_unit plus hand-written multi-cycle sequences.
// Signed vectors are added when MDU_SIGNED_EN is defined.
module tb_mult_div_unit;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
`ifdef MDU_SIGNED_EN
  logic             signed_op;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  int check_count = 0;
  int pass_count  = 0;

  logic [WIDTH-1:0] prev_hi = '0;
  logic [WIDTH-1:0] prev_lo = '0;

  typedef struct {
    logic             op;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_hi;
    logic [WIDTH-1:0] exp_lo;
    logic             exp_dbz;
    int               exp_lat;
    logic             mid_start;
  } vec_t;

  vec_t vecs[$];

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
`ifdef MDU_SIGNED_EN
    .signedOp  (signed_op),
`endif
    .opA       (op_a),
    .opB       (op_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .divByZero (div_by_zero)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string what, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", what, idx, actual, expected);
  endtask

  // Drive one operation, scramble inputs after the accept edge, optionally retrigger mid-run
  task automatic applyStimulus(input vec_t v, input int idx,
                               output int lat, output int busy_cycles, output bit timed_out);
    int k;
    @(negedge clk);
    start = 1'b1;
    op    = v.op;
    op_a  = v.a;
    op_b  = v.b;
`ifdef MDU_SIGNED_EN
    signed_op = v.sgn;
`endif
    k = 0;
    lat = 0;
    busy_cycles = 0;
    timed_out = 1'b1;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (done) begin
        lat = k - 1;
        timed_out = 1'b0;
        break;
      end
      busy_cycles += int'(busy);
      checkOutput("hi held during run", idx, hi, prev_hi);
      checkOutput("lo held during run", idx, lo, prev_lo);
      if (k == 4 && v.mid_start) checkOutput("busy after ignored start", idx, busy, 1);
      if (k == 1) begin
        start = 1'b0;
        op    = ~v.op;
        op_a  = ~v.a;
        op_b  = v.b ^ 8'h5A;
      end
      if (k == 3 && v.mid_start) begin
        start = 1'b1;
        op    = 1'b0;
        op_a  = 8'd3;
        op_b  = 8'd3;
      end
      if (k == 4 && v.mid_start) start = 1'b0;
    end
  endtask

  // Wait for done, counting negedges; start is released after the first one
  task automatic waitDone(output int k, output bit timed_out);
    k = 0;
    timed_out = 1'b1;
    while (k < 40 && timed_out) begin
      @(negedge clk);
      k++;
      if (done) timed_out = 1'b0;
      start = 1'b0;
    end
  endtask

  // Main sequence: reset checks, vector table, then back-to-back and abort sequences
  initial begin
    int lat;
    int bcy;
    int k;
    bit to;
    bit saw_done;

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    op_a  = '0;
    op_b  = '0;
`ifdef MDU_SIGNED_EN
    signed_op = 1'b0;
`endif

    vecs.push_back('{1'b0, 1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 8, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'd200, 8'd200, 8'h9C, 8'h40, 1'b0, 8, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd100, 8'd7,   8'h02, 8'h0E, 1'b0, 8, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'h55,  8'd0,   8'h55, 8'hFF, 1'b1, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 8, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd255, 8'd1,   8'h00, 8'hFF, 1'b0, 8, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd7,   8'd100, 8'h07, 8'h00, 1'b0, 8, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'd0,   8'd123, 8'h00, 8'h00, 1'b0, 8, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd200, 8'd200, 8'h00, 8'h01, 1'b0, 8, 1'b0});
`ifdef MDU_SIGNED_EN
    vecs.push_back('{1'b0, 1'b1, 8'hF9,  8'd3,   8'hFF, 8'hEB, 1'b0, 9, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'hF9,  8'd2,   8'hFF, 8'hFD, 1'b0, 9, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'hF9,  8'd3,   8'h02, 8'hEB, 1'b0, 8, 1'b0});
`endif

    repeat (3) @(negedge clk);
    checkOutput("reset busy", -1, busy, 0);
    checkOutput("reset done", -1, done, 0);
    checkOutput("reset hi", -1, hi, 0);
    checkOutput("reset lo", -1, lo, 0);
    checkOutput("reset divByZero", -1, div_by_zero, 0);

    start = 1'b1;
    op    = 1'b0;
    op_a  = 8'd13;
    op_b  = 8'd11;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("reset beats start busy", -1, busy, 0);
    @(negedge clk);
    checkOutput("idle after reset busy", -1, busy, 0);
    checkOutput("idle after reset done", -1, done, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], i, lat, bcy, to);
      checkOutput("done before timeout", i, to, 0);
      if (!to) begin
        checkOutput("hi", i, hi, vecs[i].exp_hi);
        checkOutput("lo", i, lo, vecs[i].exp_lo);
        checkOutput("divByZero", i, div_by_zero, vecs[i].exp_dbz);
        checkOutput("latency", i, lat, vecs[i].exp_lat);
        checkOutput("busy cycles", i, bcy, vecs[i].exp_lat);
        checkOutput("busy in done cycle", i, busy, 0);
        @(negedge clk);
        checkOutput("done one cycle", i, done, 0);
        checkOutput("hi held after done", i, hi, vecs[i].exp_hi);
        checkOutput("lo held after done", i, lo, vecs[i].exp_lo);
      end
      prev_hi = vecs[i].exp_hi;
      prev_lo = vecs[i].exp_lo;
    end

`ifdef MDU_SIGNED_EN
    signed_op = 1'b0;
`endif

    // Back-to-back: second start issued in the DONE cycle of the first
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    op_a  = 8'd13;
    op_b  = 8'd11;
    waitDone(k, to);
    checkOutput("b2b first done", 100, to, 0);
    checkOutput("b2b first latency", 100, k - 1, 8);
    checkOutput("b2b first hi", 100, hi, 8'h00);
    checkOutput("b2b first lo", 100, lo, 8'h8F);
    start = 1'b1;
    op    = 1'b1;
    op_a  = 8'd100;
    op_b  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b accepted busy", 101, busy, 1);
    checkOutput("b2b done dropped", 101, done, 0);
    checkOutput("b2b hi held at start", 101, hi, 8'h00);
    checkOutput("b2b lo held at start", 101, lo, 8'h8F);
    waitDone(k, to);
    checkOutput("b2b second done", 101, to, 0);
    checkOutput("b2b second latency", 101, k, 8);
    checkOutput("b2b second hi", 101, hi, 8'h02);
    checkOutput("b2b second lo", 101, lo, 8'h0E);

    // Reset four cycles into a multiply aborts it
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    op_a  = 8'd13;
    op_b  = 8'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy before abort", 102, busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", 102, busy, 0);
    checkOutput("abort done", 102, done, 0);
    checkOutput("abort hi", 102, hi, 0);
    checkOutput("abort lo", 102, lo, 0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checkOutput("no done after abort", 102, saw_done, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
